// File: rtl/sound_mixer_pkg.sv
// ---------------------------------------------------------------------------
// sound_mixer_pkg
//   Shared definitions for the sound mixer slice:
//     - IO register addresses of the mixer control registers (NR50/51/52)
//     - mixer FSM state encoding
//     - scale shift applied after the per-side volume multiply
// ---------------------------------------------------------------------------
package sound_mixer_pkg;

    // Memory-mapped control registers
    localparam logic [15:0] ADDR_NR50 = 16'hFF24;  // master volume L[6:4] / R[2:0]
    localparam logic [15:0] ADDR_NR51 = 16'hFF25;  // routing L[7:4] / R[3:0]
    localparam logic [15:0] ADDR_NR52 = 16'hFF26;  // master enable [7], channel status [3:0]

    // Volume gain is (vol + 1) in 1..8, so the product is normalised by 2^5
    localparam int unsigned SCALE_SHIFT = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_SCALE,
        ST_OUTPUT
    } mix_state_t;

endpackage : sound_mixer_pkg

// File: rtl/mixer_scale_sat.sv
// ---------------------------------------------------------------------------
// mixer_scale_sat
//   Combinational volume scale and saturation for one stereo side.
//   O_SAMPLE = sat_SAMPLE_W( floor( I_ACC * (I_VOL + 1) / 32 ) )
//
//   Ports:
//     I_ACC     signed accumulator, SAMPLE_W+2 bits
//     I_VOL     3-bit master volume field (gain = I_VOL + 1)
//     O_SAMPLE  signed, saturated output sample, SAMPLE_W bits
// ---------------------------------------------------------------------------
module mixer_scale_sat
    import sound_mixer_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 20
) (
    input  logic signed [SAMPLE_W+1:0] I_ACC,
    input  logic        [2:0]          I_VOL,
    output logic signed [SAMPLE_W-1:0] O_SAMPLE
);

    // Accumulator (SAMPLE_W+2) times a 4-bit gain fits in SAMPLE_W+6 bits
    localparam int unsigned PW = SAMPLE_W + 6;

    logic signed [PW-1:0] acc_x;
    logic signed [PW-1:0] gain_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic                 sign_bit;
    logic [PW-SAMPLE_W-1:0] upper_bits;

    assign acc_x   = PW'(I_ACC);
    assign gain_x  = $signed({{(PW-3){1'b0}}, I_VOL} + {{(PW-1){1'b0}}, 1'b1});
    assign prod    = acc_x * gain_x;
    assign shifted = prod >>> SCALE_SHIFT;

    // In range only when every bit above the output sign bit matches the sign
    assign sign_bit   = shifted[PW-1];
    assign upper_bits = shifted[PW-2:SAMPLE_W-1];

    always_comb begin
        O_SAMPLE = shifted[SAMPLE_W-1:0];
        if (!sign_bit && (|upper_bits)) begin
            O_SAMPLE = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (sign_bit && !(&upper_bits)) begin
            O_SAMPLE = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end

endmodule : mixer_scale_sat

// File: rtl/sound_mixer.sv
// ---------------------------------------------------------------------------
// sound_mixer
//   Stereo mixer for four channel waveforms with NR50/NR51/NR52 control.
//   On each I_STROBE (accepted only while idle) the waveforms and channel
//   status are snapshotted, routed/accumulated one channel per cycle,
//   scaled by the per-side master volume, saturated and presented with a
//   one-cycle O_SAMPLE_VALID pulse six cycles after the strobe.
//
//   Ports:
//     I_CLK                 system clock
//     I_RESET               asynchronous active-high reset
//     I_STROBE              request for the next stereo sample
//     I_IOREG_ADDR          IO register address
//     IO_IOREG_DATA         IO register data (driven only on a matching read)
//     I_IOREG_WE_L/RE_L     active-low write/read strobes
//     I_CH1..4_WAVEFORM     signed channel samples
//     I_CH_ON               channel active flags (bit i = channel i+1)
//     O_LEFT/RIGHT_SAMPLE   mixed signed output samples
//     O_SAMPLE_VALID        one-cycle pulse when new samples are presented
//     O_SOUND_EN            master enable (NR52 bit 7)
// ---------------------------------------------------------------------------
module sound_mixer
    import sound_mixer_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned SAMPLE_W = 20
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_STROBE,
    input  logic        [15:0]         I_IOREG_ADDR,
    inout  wire         [7:0]          IO_IOREG_DATA,
    input  logic                       I_IOREG_WE_L,
    input  logic                       I_IOREG_RE_L,
    input  logic signed [SAMPLE_W-1:0] I_CH1_WAVEFORM,
    input  logic signed [SAMPLE_W-1:0] I_CH2_WAVEFORM,
    input  logic signed [SAMPLE_W-1:0] I_CH3_WAVEFORM,
    input  logic signed [SAMPLE_W-1:0] I_CH4_WAVEFORM,
    input  logic        [NUM_CH-1:0]   I_CH_ON,
    output logic signed [SAMPLE_W-1:0] O_LEFT_SAMPLE,
    output logic signed [SAMPLE_W-1:0] O_RIGHT_SAMPLE,
    output logic                       O_SAMPLE_VALID,
    output logic                       O_SOUND_EN
);

    localparam int unsigned ACC_W = SAMPLE_W + 2;
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    logic [7:0] nr50;
    logic [7:0] nr51;
    logic       master_en;

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            nr50      <= '0;
            nr51      <= '0;
            master_en <= 1'b0;
        end else if (!I_IOREG_WE_L) begin
            unique case (I_IOREG_ADDR)
                ADDR_NR52: begin
                    master_en <= IO_IOREG_DATA[7];
                    // Powering down wipes the volume and routing registers
                    if (!IO_IOREG_DATA[7]) begin
                        nr50 <= '0;
                        nr51 <= '0;
                    end
                end
                ADDR_NR50: if (master_en) nr50 <= IO_IOREG_DATA;
                ADDR_NR51: if (master_en) nr51 <= IO_IOREG_DATA;
                default: ;
            endcase
        end
    end

    assign O_SOUND_EN = master_en;

    // -----------------------------------------------------------------------
    // Register read-back
    // -----------------------------------------------------------------------
    logic [7:0] rd_data;
    logic       rd_hit;

    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        if (!I_IOREG_RE_L) begin
            unique case (I_IOREG_ADDR)
                ADDR_NR50: begin rd_data = nr50; rd_hit = 1'b1; end
                ADDR_NR51: begin rd_data = nr51; rd_hit = 1'b1; end
                ADDR_NR52: begin
                    rd_data = {master_en, 3'b111, 4'(I_CH_ON)};
                    rd_hit  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign IO_IOREG_DATA = rd_hit ? rd_data : 8'bz;

    // -----------------------------------------------------------------------
    // Mixer datapath and FSM
    // -----------------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] wave_in [NUM_CH];
    logic signed [SAMPLE_W-1:0] wave_q  [NUM_CH];
    logic        [NUM_CH-1:0]   on_q;
    logic        [IDX_W-1:0]    ch_idx;
    logic signed [ACC_W-1:0]    acc_l;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    ch_ext;
    logic        [2:0]          route_l_bit;
    logic        [2:0]          route_r_bit;
    logic signed [SAMPLE_W-1:0] scaled_l;
    logic signed [SAMPLE_W-1:0] scaled_r;
    mix_state_t                 state;

    assign wave_in[0] = I_CH1_WAVEFORM;
    assign wave_in[1] = I_CH2_WAVEFORM;
    assign wave_in[2] = I_CH3_WAVEFORM;
    assign wave_in[3] = I_CH4_WAVEFORM;

    assign ch_ext      = ACC_W'(wave_q[ch_idx]);
    assign route_r_bit = 3'(ch_idx);
    assign route_l_bit = 3'(ch_idx) + 3'd4;

    // Volume and routing are read live, so register writes during a mix
    // affect the remaining accumulate steps and the scale step.
    mixer_scale_sat #(.SAMPLE_W(SAMPLE_W)) u_scale_l (
        .I_ACC    (acc_l),
        .I_VOL    (nr50[6:4]),
        .O_SAMPLE (scaled_l)
    );

    mixer_scale_sat #(.SAMPLE_W(SAMPLE_W)) u_scale_r (
        .I_ACC    (acc_r),
        .I_VOL    (nr50[2:0]),
        .O_SAMPLE (scaled_r)
    );

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state          <= ST_IDLE;
            ch_idx         <= '0;
            acc_l          <= '0;
            acc_r          <= '0;
            on_q           <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                wave_q[i] <= '0;
            end
            O_LEFT_SAMPLE  <= '0;
            O_RIGHT_SAMPLE <= '0;
            O_SAMPLE_VALID <= 1'b0;
        end else begin
            O_SAMPLE_VALID <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (I_STROBE) begin
                        for (int unsigned i = 0; i < NUM_CH; i++) begin
                            wave_q[i] <= wave_in[i];
                        end
                        on_q   <= I_CH_ON;
                        acc_l  <= '0;
                        acc_r  <= '0;
                        ch_idx <= '0;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (on_q[ch_idx]) begin
                        if (nr51[route_l_bit]) acc_l <= acc_l + ch_ext;
                        if (nr51[route_r_bit]) acc_r <= acc_r + ch_ext;
                    end
                    if (ch_idx == IDX_W'(NUM_CH - 1)) begin
                        state <= ST_SCALE;
                    end else begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
                ST_SCALE: begin
                    // Samples are committed here so they appear together
                    // with the valid pulse in the OUTPUT cycle.
                    O_LEFT_SAMPLE  <= master_en ? scaled_l : '0;
                    O_RIGHT_SAMPLE <= master_en ? scaled_r : '0;
                    O_SAMPLE_VALID <= 1'b1;
                    state          <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : sound_mixer

// File: tb/tb_sound_mixer.sv
// ---------------------------------------------------------------------------
// tb_sound_mixer
//   Self-checking bench for sound_mixer: directed register accesses,
//   a table of mix vectors with hand-computed results, and hand-written
//   multi-cycle sequences for strobe timing, live register writes,
//   power-down mid-mix and reset mid-mix.
// ---------------------------------------------------------------------------
module tb_sound_mixer;

    localparam int W = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               strobe = 1'b0;
    logic [15:0]        addr = '0;
    logic               we_l = 1'b1;
    logic               re_l = 1'b1;
    logic               drv = 1'b0;
    logic [7:0]         wdata = '0;
    wire  [7:0]         iodata;
    logic signed [W-1:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
    logic [3:0]         ch_on = 4'b0101;
    logic signed [W-1:0] left_s, right_s;
    logic               valid, sound_en;

    assign iodata = drv ? wdata : 8'bz;

    always #5 clk = ~clk;

    sound_mixer #(.NUM_CH(4), .SAMPLE_W(W)) dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_STROBE       (strobe),
        .I_IOREG_ADDR   (addr),
        .IO_IOREG_DATA  (iodata),
        .I_IOREG_WE_L   (we_l),
        .I_IOREG_RE_L   (re_l),
        .I_CH1_WAVEFORM (w1),
        .I_CH2_WAVEFORM (w2),
        .I_CH3_WAVEFORM (w3),
        .I_CH4_WAVEFORM (w4),
        .I_CH_ON        (ch_on),
        .O_LEFT_SAMPLE  (left_s),
        .O_RIGHT_SAMPLE (right_s),
        .O_SAMPLE_VALID (valid),
        .O_SOUND_EN     (sound_en)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; drv = 1'b1; we_l = 1'b0;
        @(negedge clk);
        we_l = 1'b1; drv = 1'b0; addr = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; re_l = 1'b0;
        #1 d = iodata;
        re_l = 1'b1; addr = '0;
    endtask

    // Strobe once; expect a single valid pulse six cycles later carrying
    // the given samples, with outputs held until then.
    task automatic run_mix(input string name, input int exp_l, input int exp_r);
        logic signed [W-1:0] prev_l, prev_r;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                prev_l = left_s;
                prev_r = right_s;
            end
            chk({name, "_valid"}, 32'(valid), 32'(k == 6));
            if (k == 5) begin
                chk({name, "_hold_l"}, left_s, prev_l);
                chk({name, "_hold_r"}, right_s, prev_r);
            end
            if (k == 6) begin
                chk({name, "_left"}, left_s, exp_l);
                chk({name, "_right"}, right_s, exp_r);
            end
            strobe = (k == 0);
        end
    endtask

    typedef struct {
        string               name;
        logic [7:0]          nr50;
        logic [7:0]          nr51;
        logic [3:0]          on;
        logic signed [W-1:0] a, b, c, d;
        int                  el, er;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [7:0] v50,
                                input logic [7:0] v51, input logic [3:0] on,
                                input int a, input int b, input int c,
                                input int d, input int el, input int er);
        vec_t v;
        v.name = n; v.nr50 = v50; v.nr51 = v51; v.on = on;
        v.a = a[W-1:0]; v.b = b[W-1:0]; v.c = c[W-1:0]; v.d = d[W-1:0];
        v.el = el; v.er = er;
        return v;
    endfunction

    vec_t       vecs[6];
    logic [7:0] rd;

    initial begin
        vecs[0] = mk("unity",   8'h77, 8'hFF, 4'b1111, 1000, 1000, 1000, 1000, 1000, 1000);
        vecs[1] = mk("ch1_neg", 8'h30, 8'h10, 4'b0001, -640, 777, 777, 777, -80, 0);
        vecs[2] = mk("fullscl", 8'h77, 8'hFF, 4'b1111, 524287, 524287, 524287, 524287, 524287, 524287);
        vecs[3] = mk("pan",     8'h70, 8'h21, 4'b1111, 3200, -1000, 50000, 7, -250, 100);
        vecs[4] = mk("floor",   8'h02, 8'h0F, 4'b0110, 999, -1, -2, 999, 0, -1);
        vecs[5] = mk("left4",   8'h50, 8'hF0, 4'b1010, 12345, 100, 12345, 60, 30, 0);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_left", left_s, 0);
        chk("rst_right", right_s, 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_sound_en", 32'(sound_en), 0);
        bus_read(16'hFF26, rd);
        chk("rst_nr52", 32'(rd), 32'h75);
        bus_read(16'hFF24, rd);
        chk("rst_nr50", 32'(rd), 0);

        // Writes to NR50 are ignored while the master is off
        bus_write(16'hFF24, 8'h77);
        bus_read(16'hFF24, rd);
        chk("nr50_locked", 32'(rd), 0);

        // Power up; only bit 7 of NR52 is writable
        bus_write(16'hFF26, 8'hFF);
        bus_read(16'hFF26, rd);
        chk("nr52_on", 32'(rd), 32'hF5);
        chk("sound_en_on", 32'(sound_en), 1);

        // ---------------- vector table ----------------
        for (int i = 0; i < 6; i++) begin
            bus_write(16'hFF25, vecs[i].nr51);
            bus_write(16'hFF24, vecs[i].nr50);
            bus_read(16'hFF25, rd);
            chk({vecs[i].name, "_nr51_rb"}, 32'(rd), 32'(vecs[i].nr51));
            w1 = vecs[i].a; w2 = vecs[i].b; w3 = vecs[i].c; w4 = vecs[i].d;
            ch_on = vecs[i].on;
            run_mix(vecs[i].name, vecs[i].el, vecs[i].er);
        end

        // ---------------- strobe spacing ----------------
        bus_write(16'hFF25, 8'hFF);
        bus_write(16'hFF24, 8'h77);
        w1 = 20'sd1000; w2 = 20'sd1000; w3 = 20'sd1000; w4 = 20'sd1000;
        ch_on = 4'b1111;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("spacing_valid_c%0d", k), 32'(valid), 32'(k == 6 || k == 13));
            if (k == 13) chk("spacing_left", left_s, 1000);
            strobe = (k == 0 || k == 3 || k == 7);
        end

        // ---------------- NR50 written mid-mix is used live ----------------
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                chk("live_nr50_valid", 32'(valid), 1);
                chk("live_nr50_left", left_s, 500);
                chk("live_nr50_right", right_s, 500);
            end
            strobe = (k == 0);
            if (k == 3) begin addr = 16'hFF24; wdata = 8'h33; drv = 1'b1; we_l = 1'b0; end
            if (k == 4) begin we_l = 1'b1; drv = 1'b0; addr = '0; end
        end

        // ---------------- power down during ACCUM ----------------
        bus_write(16'hFF24, 8'h77);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("pwrdn_valid_c%0d", k), 32'(valid), 32'(k == 6));
            if (k == 6) begin
                chk("pwrdn_left", left_s, 0);
                chk("pwrdn_right", right_s, 0);
            end
            strobe = (k == 0);
            if (k == 2) begin addr = 16'hFF26; wdata = 8'h00; drv = 1'b1; we_l = 1'b0; end
            if (k == 3) begin we_l = 1'b1; drv = 1'b0; addr = '0; end
        end
        bus_read(16'hFF24, rd);
        chk("pwrdn_nr50", 32'(rd), 0);
        bus_read(16'hFF25, rd);
        chk("pwrdn_nr51", 32'(rd), 0);
        chk("pwrdn_sound_en", 32'(sound_en), 0);

        // ---------------- reset during ACCUM ----------------
        bus_write(16'hFF26, 8'h80);
        bus_write(16'hFF25, 8'hFF);
        bus_write(16'hFF24, 8'h77);
        run_mix("pre_reset", 1000, 1000);
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("midrst_valid_c%0d", k), 32'(valid), 0);
            strobe = (k == 0);
            if (k == 3) rst = 1'b1;
            if (k == 4) rst = 1'b0;
        end
        chk("midrst_left", left_s, 0);
        chk("midrst_right", right_s, 0);
        chk("midrst_sound_en", 32'(sound_en), 0);

        // Fresh mix after reset release
        bus_write(16'hFF26, 8'h80);
        bus_write(16'hFF25, 8'hFF);
        bus_write(16'hFF24, 8'h77);
        run_mix("post_reset", 1000, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_sound_mixer
